// File: rtl/step_seq_pkg.sv
// Shared definitions for the CPU step sequencer: state encodings and
// default counter widths.
package step_seq_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int CYC_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BURST = 2'b10,
    ST_BREAK = 2'b11
  } state_e;

endpackage

// File: rtl/step_sequencer.sv
// Run / single-step / breakpoint controller that gates the CPU pipeline
// clock enable, with an inline burst down-counter and enabled-cycle counter.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int CYC_W = CYC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step_pulse,
  input  logic             halt,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             bp_hit,
  output logic             cpu_en,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CYC_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] remaining
);

  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_next_remaining;
  logic [CNT_W-1:0] w_load_len;
  logic [CYC_W-1:0] r_cycle_cnt;
  logic             r_bp_mask;
  logic             w_next_bp_mask;
  logic             w_bp;

  // A zero burst length still executes one instruction.
  assign w_load_len = (burst_len == '0) ? CNT_W'(1) : burst_len;
  // The mask lets the instruction that tripped the breakpoint be stepped past.
  assign w_bp       = bp_hit & ~r_bp_mask;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_next_state     = r_state;
    w_next_remaining = r_remaining;
    if (halt) begin
      w_next_state     = ST_HALT;
      w_next_remaining = '0;
    end else begin
      case (r_state)
        ST_HALT: begin
          if (run) begin
            w_next_state = ST_RUN;
          end else if (step_pulse) begin
            w_next_state     = ST_BURST;
            w_next_remaining = w_load_len;
          end
        end
        ST_RUN: begin
          if (w_bp)      w_next_state = ST_BREAK;
          else if (!run) w_next_state = ST_HALT;
        end
        ST_BURST: begin
          if (w_bp) begin
            w_next_state = ST_BREAK;
          end else if (r_remaining == CNT_W'(1)) begin
            w_next_state     = ST_HALT;
            w_next_remaining = '0;
          end else begin
            w_next_remaining = r_remaining - CNT_W'(1);
          end
        end
        ST_BREAK: begin
          if (step_pulse) begin
            w_next_state     = ST_BURST;
            w_next_remaining = w_load_len;
          end else if (!run) begin
            w_next_state = ST_HALT;
          end
        end
        default: w_next_state = ST_HALT;
      endcase
    end

    w_next_bp_mask = r_bp_mask;
    if (r_state == ST_BREAK && w_next_state != ST_BREAK) w_next_bp_mask = 1'b1;
    else if (cpu_en)                                      w_next_bp_mask = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_HALT;
      r_remaining <= '0;
      r_cycle_cnt <= '0;
      r_bp_mask   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_remaining <= w_next_remaining;
      r_cycle_cnt <= r_cycle_cnt + CYC_W'(cpu_en);
      r_bp_mask   <= w_next_bp_mask;
    end
  end

  assign cpu_en    = (r_state == ST_RUN) || (r_state == ST_BURST);
  assign halted    = (r_state == ST_HALT) || (r_state == ST_BREAK);
  assign state     = r_state;
  assign cycle_cnt = r_cycle_cnt;
  assign remaining = r_remaining;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: directed scenarios plus a
// randomized run against a flag-based behavioural model.
module tb_step_sequencer;

  localparam int CNT_W = 16;
  localparam int CYC_W = 8;

  logic             clk;
  logic             reset;
  logic             run;
  logic             step_pulse;
  logic             halt;
  logic [CNT_W-1:0] burst_len;
  logic             bp_hit;
  logic             cpu_en;
  logic             halted;
  logic [1:0]       state;
  logic [CYC_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] remaining;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: CPU running freely, burst in progress, stopped at a breakpoint.
  bit m_run, m_burst, m_brk, m_mask;
  int m_rem, m_cnt;

  step_sequencer #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .reset(reset), .run(run), .step_pulse(step_pulse),
    .halt(halt), .burst_len(burst_len), .bp_hit(bp_hit),
    .cpu_en(cpu_en), .halted(halted), .state(state),
    .cycle_cnt(cycle_cnt), .remaining(remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_run = 0; m_burst = 0; m_brk = 0; m_mask = 0; m_rem = 0; m_cnt = 0;
  endfunction

  function automatic void model_clock();
    bit en, was_brk, bp;
    int ld;
    en      = m_run || m_burst;
    was_brk = m_brk;
    ld      = (burst_len == 0) ? 1 : int'(burst_len);
    bp      = en && bp_hit && !m_mask;
    if (en) begin
      m_cnt  = (m_cnt + 1) % (1 << CYC_W);
      m_mask = 0;
    end
    if (halt) begin
      m_run = 0; m_burst = 0; m_brk = 0; m_rem = 0;
    end else if (bp) begin
      m_run = 0; m_burst = 0; m_brk = 1;
    end else if (m_burst) begin
      if (m_rem == 1) begin m_burst = 0; m_rem = 0; end
      else m_rem = m_rem - 1;
    end else if (m_run) begin
      if (!run) m_run = 0;
    end else if (m_brk) begin
      if (step_pulse) begin m_brk = 0; m_burst = 1; m_rem = ld; end
      else if (!run) m_brk = 0;
    end else begin
      if (run) m_run = 1;
      else if (step_pulse) begin m_burst = 1; m_rem = ld; end
    end
    if (was_brk && !m_brk) m_mask = 1;
  endfunction

  function automatic int model_state();
    if (m_brk)   return 3;
    if (m_burst) return 2;
    if (m_run)   return 1;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_clock();
    #1;
  endtask

  task automatic idle_inputs();
    run = 0; step_pulse = 0; halt = 0; bp_hit = 0; burst_len = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; run = 1; step_pulse = 1; burst_len = 5;
    tick();
    tick();
    n_checks++;
    if (state !== 2'd0 || cpu_en !== 1'b0 || halted !== 1'b1 ||
        cycle_cnt !== '0 || remaining !== '0) begin
      n_fail++;
      $display("FAIL reset: state=%0d cpu_en=%0d halted=%0d cnt=%0d rem=%0d, required 0 0 1 0 0",
               state, cpu_en, halted, cycle_cnt, remaining);
    end
    reset = 0;
    idle_inputs();
  endtask

  task automatic test_burst3();
    do_reset();
    step_pulse = 1; burst_len = 3;
    tick();
    step_pulse = 0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (cpu_en !== 1'b1 || remaining !== CNT_W'(3 - i) || state !== 2'd2) begin
        n_fail++;
        $display("FAIL burst3_cycle%0d: cpu_en=%0d rem=%0d state=%0d, required 1 %0d 2",
                 i, cpu_en, remaining, state, 3 - i);
      end
      tick();
    end
    n_checks++;
    if (state !== 2'd0 || cpu_en !== 1'b0 || remaining !== '0 || cycle_cnt !== CYC_W'(3)) begin
      n_fail++;
      $display("FAIL burst3_end: state=%0d cpu_en=%0d rem=%0d cnt=%0d, required 0 0 0 3",
               state, cpu_en, remaining, cycle_cnt);
    end
  endtask

  task automatic test_burst_zero();
    do_reset();
    step_pulse = 1; burst_len = 0;
    tick();
    step_pulse = 0;
    n_checks++;
    if (cpu_en !== 1'b1 || remaining !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL burst0_en: cpu_en=%0d rem=%0d, required 1 1", cpu_en, remaining);
    end
    tick();
    n_checks++;
    if (state !== 2'd0 || cycle_cnt !== CYC_W'(1)) begin
      n_fail++;
      $display("FAIL burst0_end: state=%0d cnt=%0d, required 0 1", state, cycle_cnt);
    end
  endtask

  task automatic test_breakpoint();
    do_reset();
    run = 1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    bp_hit = 1;
    tick();
    bp_hit = 0;
    n_checks++;
    if (state !== 2'd3 || cycle_cnt !== CYC_W'(5) || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_break: state=%0d cnt=%0d halted=%0d, required 3 5 1", state, cycle_cnt, halted);
    end
    tick();
    tick();
    n_checks++;
    if (state !== 2'd3) begin
      n_fail++;
      $display("FAIL bp_hold: state=%0d, required 3", state);
    end
    step_pulse = 1; burst_len = 1; run = 0; bp_hit = 1;
    tick();
    step_pulse = 0;
    n_checks++;
    if (state !== 2'd2 || cpu_en !== 1'b1 || remaining !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL bp_step: state=%0d cpu_en=%0d rem=%0d, required 2 1 1", state, cpu_en, remaining);
    end
    tick();
    bp_hit = 0;
    n_checks++;
    if (state !== 2'd0 || cycle_cnt !== CYC_W'(6)) begin
      n_fail++;
      $display("FAIL bp_masked: state=%0d cnt=%0d, required 0 6", state, cycle_cnt);
    end
  endtask

  task automatic test_halt_over_bp();
    do_reset();
    step_pulse = 1; burst_len = 8;
    tick();
    step_pulse = 0;
    tick();
    tick();
    halt = 1; bp_hit = 1;
    tick();
    halt = 0; bp_hit = 0;
    n_checks++;
    if (state !== 2'd0 || remaining !== '0 || cycle_cnt !== CYC_W'(3)) begin
      n_fail++;
      $display("FAIL halt_bp: state=%0d rem=%0d cnt=%0d, required 0 0 3", state, remaining, cycle_cnt);
    end
  endtask

  task automatic test_final_cycle_bp();
    do_reset();
    step_pulse = 1; burst_len = 2;
    tick();
    step_pulse = 0;
    tick();
    bp_hit = 1;
    tick();
    bp_hit = 0;
    n_checks++;
    if (state !== 2'd3 || remaining !== CNT_W'(1) || cycle_cnt !== CYC_W'(2)) begin
      n_fail++;
      $display("FAIL final_bp: state=%0d rem=%0d cnt=%0d, required 3 1 2", state, remaining, cycle_cnt);
    end
  endtask

  task automatic test_run_step_and_reset();
    do_reset();
    run = 1; step_pulse = 1; burst_len = 4;
    tick();
    step_pulse = 0;
    n_checks++;
    if (state !== 2'd1 || cpu_en !== 1'b1) begin
      n_fail++;
      $display("FAIL run_over_step: state=%0d cpu_en=%0d, required 1 1", state, cpu_en);
    end
    tick(); tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    n_checks++;
    if (state !== 2'd0 || cycle_cnt !== '0 || cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: state=%0d cnt=%0d cpu_en=%0d, required 0 0 0", state, cycle_cnt, cpu_en);
    end
    run = 0; step_pulse = 1; burst_len = 10;
    tick();
    step_pulse = 0;
    tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    n_checks++;
    if (state !== 2'd0 || remaining !== '0 || cycle_cnt !== '0 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_burst: state=%0d rem=%0d cnt=%0d halted=%0d, required 0 0 0 1",
               state, remaining, cycle_cnt, halted);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run = 1;
    for (int i = 0; i < 300 && m_cnt != (1 << CYC_W) - 1; i++) tick();
    n_checks++;
    if (cycle_cnt !== {CYC_W{1'b1}} || state !== 2'd1) begin
      n_fail++;
      $display("FAIL wrap_pre: cnt=%0d state=%0d, required %0d 1", cycle_cnt, state, (1 << CYC_W) - 1);
    end
    tick();
    n_checks++;
    if (cycle_cnt !== '0 || state !== 2'd1) begin
      n_fail++;
      $display("FAIL wrap: cnt=%0d state=%0d, required 0 1", cycle_cnt, state);
    end
    run = 0;
    tick();
  endtask

  task automatic test_random();
    int shown;
    shown = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) run = ~run;
      step_pulse = ($urandom_range(0, 5) == 0);
      halt       = ($urandom_range(0, 24) == 0);
      bp_hit     = ($urandom_range(0, 4) == 0);
      burst_len  = CNT_W'($urandom_range(0, 5));
      tick();
      n_checks++;
      if (state !== 2'(model_state()) || cpu_en !== (m_run || m_burst) ||
          halted !== (m_brk || !(m_run || m_burst)) ||
          cycle_cnt !== CYC_W'(m_cnt) || remaining !== CNT_W'(m_rem)) begin
        n_fail++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random@%0d: state=%0d cpu_en=%0d halted=%0d cnt=%0d rem=%0d, required state=%0d cnt=%0d rem=%0d",
                   i, state, cpu_en, halted, cycle_cnt, remaining, model_state(), m_cnt, m_rem);
        end
      end
    end
    idle_inputs();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    model_reset();
    test_reset();
    test_burst3();
    test_burst_zero();
    test_breakpoint();
    test_halt_over_bp();
    test_final_cycle_bp();
    test_run_step_and_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
